// File: rtl/cnc_feeder.sv
// Initiator-side driver for the CNC serial interface: streams one parallel request onto
// IN_VALID/MODE/IN, gathers the OUT_VALID/OUT beats and returns them as one response.
// Optional CNC_FEEDER_TIMEOUT_EN adds a per-beat watchdog that ends the wait with rsp_err=1.
module cnc_feeder #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OUT_W       = 17,
  parameter int unsigned OUT_BEATS   = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_mode,
  input  logic [DATA_W-1:0]          req_a_re,
  input  logic [DATA_W-1:0]          req_a_im,
  input  logic [DATA_W-1:0]          req_b_re,
  input  logic [DATA_W-1:0]          req_b_im,
  output logic                       IN_VALID,
  output logic [1:0]                 MODE,
  output logic [DATA_W-1:0]          IN,
  input  logic                       OUT_VALID,
  input  logic [OUT_W-1:0]           OUT,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [OUT_BEATS*OUT_W-1:0] rsp_data,
  output logic                       rsp_err
);

  localparam int unsigned BEAT_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam int unsigned RSP_W  = OUT_BEATS * OUT_W;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          send_cnt_q, send_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]   a_im_q, a_im_d;
  logic [DATA_W-1:0]   b_re_q, b_re_d;
  logic [DATA_W-1:0]   b_im_q, b_im_d;
  logic                in_valid_d;
  logic [1:0]          mode_d;
  logic [DATA_W-1:0]   in_d;
  logic                rsp_valid_d;
  logic [RSP_W-1:0]    rsp_data_d;
  logic                last_beat;

`ifdef CNC_FEEDER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Idle is the only accepting state; held low while reset is asserted.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign last_beat = (beat_cnt_q == BEAT_W'(OUT_BEATS - 1));

  // Next-state and next-output logic; bus fields are zero whenever IN_VALID is low.
  always_comb begin
    state_d     = state_q;
    send_cnt_d  = send_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    a_im_d      = a_im_q;
    b_re_d      = b_re_q;
    b_im_d      = b_im_q;
    in_valid_d  = 1'b0;
    mode_d      = 2'b00;
    in_d        = '0;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
`ifdef CNC_FEEDER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_im_d     = req_a_im;
          b_re_d     = req_b_re;
          b_im_d     = req_b_im;
          in_valid_d = 1'b1;
          mode_d     = req_mode;
          in_d       = req_a_re;
          send_cnt_d = 2'd1;
          beat_cnt_d = '0;
          rsp_data_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        // send_cnt wraps to 0 once the fourth beat is on the bus.
        if (send_cnt_q == 2'd0) begin
          state_d = S_WAIT;
`ifdef CNC_FEEDER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          in_valid_d = 1'b1;
          send_cnt_d = send_cnt_q + 2'd1;
          case (send_cnt_q)
            2'd1:    in_d = a_im_q;
            2'd2:    in_d = b_re_q;
            default: in_d = b_im_q;
          endcase
        end
      end
      S_WAIT: begin
        if (OUT_VALID) begin
          for (int unsigned i = 0; i < OUT_BEATS; i++) begin
            if (beat_cnt_q == BEAT_W'(i)) rsp_data_d[i*OUT_W +: OUT_W] = OUT;
          end
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
`ifdef CNC_FEEDER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (last_beat) begin
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
`ifdef CNC_FEEDER_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef CNC_FEEDER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      send_cnt_q <= 2'd0;
      beat_cnt_q <= '0;
      a_im_q     <= '0;
      b_re_q     <= '0;
      b_im_q     <= '0;
      IN_VALID   <= 1'b0;
      MODE       <= 2'b00;
      IN         <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state_q    <= state_d;
      send_cnt_q <= send_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      a_im_q     <= a_im_d;
      b_re_q     <= b_re_d;
      b_im_q     <= b_im_d;
      IN_VALID   <= in_valid_d;
      MODE       <= mode_d;
      IN         <= in_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
    end
  end

`ifdef CNC_FEEDER_TIMEOUT_EN
  // Watchdog counter and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_cnc_feeder.sv
// Scoreboard bench for cnc_feeder: expected bus beats and responses are queued when
// stimulus is driven and checked by a negedge monitor. Honours CNC_FEEDER_TIMEOUT_EN.
module tb_cnc_feeder;

`ifdef CNC_FEEDER_TIMEOUT_EN
  localparam int unsigned TO_CYC = 20;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  typedef struct packed {
    logic [33:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [7:0]  req_a_re, req_a_im, req_b_re, req_b_im;
  logic        IN_VALID;
  logic [1:0]  MODE;
  logic [7:0]  IN;
  logic        OUT_VALID;
  logic [16:0] OUT;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [33:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_in[$];
  rsp_t       exp_rsp[$];

  int cyc = 0;
  int run_len = 0;
  int rsp_seen = 0;
  int hs_cyc = 0;
  bit hs_seen = 1'b0;
  logic [9:0] in_exp;

  cnc_feeder #(.DATA_W(8), .OUT_W(17), .OUT_BEATS(2), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a_re(req_a_re), .req_a_im(req_a_im), .req_b_re(req_b_re), .req_b_im(req_b_im),
    .IN_VALID(IN_VALID), .MODE(MODE), .IN(IN),
    .OUT_VALID(OUT_VALID), .OUT(OUT),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: bus beats, burst length, burst spacing and responses against the queues.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      run_len = 0;
    end else begin
      if (IN_VALID) begin
        if (run_len == 0 && hs_seen) check("b2b_gap", 64'(cyc - hs_cyc >= 2), 64'd1);
        run_len++;
        if (exp_in.size() == 0) begin
          check("in_unexp", 64'(IN_VALID), 64'd0);
        end else begin
          in_exp = exp_in.pop_front();
          check("in_beat", 64'({MODE, IN}), 64'(in_exp));
        end
      end else begin
        check("idle_bus", 64'({MODE, IN}), 64'd0);
        if (run_len != 0) begin
          check("in_len", 64'(run_len), 64'd4);
          run_len = 0;
        end
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_unexp", 64'(rsp_valid), 64'd0);
        end else begin
          check("rsp_data", 64'(rsp_data), 64'(exp_rsp[0].data));
          check("rsp_err", 64'(rsp_err), 64'(exp_rsp[0].err));
          if (rsp_ready) begin
            void'(exp_rsp.pop_front());
            rsp_seen++;
            hs_cyc = cyc;
            hs_seen = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_tmo", 64'(req_ready), 64'd1);
  endtask

  // Drive a request that is accepted on the next edge and queue its four beats.
  task automatic drive_req(input logic [1:0] m, input logic [7:0] ar, input logic [7:0] ai,
                           input logic [7:0] br, input logic [7:0] bi);
    req_valid = 1'b1;
    req_mode = m;
    req_a_re = ar; req_a_im = ai; req_b_re = br; req_b_im = bi;
    exp_in.push_back({m, ar});
    exp_in.push_back({2'b00, ai});
    exp_in.push_back({2'b00, br});
    exp_in.push_back({2'b00, bi});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Called with beat 1 on the bus; optionally injects OUT_VALID during SEND, then waits for WAIT.
  task automatic finish_send(input bit junk);
    int n = 0;
    if (junk) begin
      OUT_VALID = 1'b1; OUT = 17'h1ABCD;
      @(posedge clk); #1;
      @(posedge clk); #1;
      OUT_VALID = 1'b0; OUT = '0;
    end
    while (IN_VALID && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_tmo", 64'(IN_VALID), 64'd0);
  endtask

  task automatic send_req(input logic [1:0] m, input logic [7:0] ar, input logic [7:0] ai,
                          input logic [7:0] br, input logic [7:0] bi, input bit junk);
    wait_ready();
    drive_req(m, ar, ai, br, bi);
    finish_send(junk);
  endtask

  task automatic cnc_result(input logic [16:0] v0, input logic [16:0] v1, input int gap);
    OUT_VALID = 1'b1; OUT = v0;
    @(posedge clk); #1;
    OUT_VALID = 1'b0; OUT = '0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    check("rsp_early", 64'(rsp_valid), 64'd0);
    OUT_VALID = 1'b1; OUT = v1;
    exp_rsp.push_back('{data: {v1, v0}, err: 1'b0});
    @(posedge clk); #1;
    OUT_VALID = 1'b0; OUT = '0;
    check("rsp_lat", 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    int start = rsp_seen;
    while (rsp_seen == start && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_tmo", 64'(rsp_seen == start), 64'd0);
  endtask

  initial begin
    int vcount;
    rst = 1'b1; req_valid = 1'b0; req_mode = '0;
    req_a_re = '0; req_a_im = '0; req_b_re = '0; req_b_im = '0;
    OUT_VALID = 1'b0; OUT = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_in_valid", 64'(IN_VALID), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Basic operation
    send_req(2'b01, 8'h03, 8'hFC, 8'hFE, 8'h05, 1'b0);
    cnc_result(17'h00007, 17'h1FFF0, 0);
    wait_rsp(50);

    // Backpressure with a second request pending
    send_req(2'b10, 8'h7F, 8'h80, 8'h01, 8'hFF, 1'b0);
    rsp_ready = 1'b0;
    cnc_result(17'h0ABCD, 17'h10001, 0);
    req_valid = 1'b1; req_mode = 2'b11;
    req_a_re = 8'h11; req_a_im = 8'h22; req_b_re = 8'h33; req_b_im = 8'h44;
    repeat (10) begin
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_rsp_valid", 64'(rsp_valid), 64'd0);
    check("hs_ready", 64'(req_ready), 64'd1);
    exp_in.push_back({2'b11, 8'h11});
    exp_in.push_back({2'b00, 8'h22});
    exp_in.push_back({2'b00, 8'h33});
    exp_in.push_back({2'b00, 8'h44});
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Gapped result, with OUT_VALID noise during SEND
    finish_send(1'b1);
    cnc_result(17'h00111, 17'h1F00F, 3);
    wait_rsp(50);

    // Reset at beat 2 of SEND
    wait_ready();
    req_valid = 1'b1; req_mode = 2'b01;
    req_a_re = 8'hA1; req_a_im = 8'hA2; req_b_re = 8'hA3; req_b_im = 8'hA4;
    exp_in.push_back({2'b01, 8'hA1});
    exp_in.push_back({2'b00, 8'hA2});
    exp_in.push_back({2'b00, 8'hA3});
    exp_in.push_back({2'b00, 8'hA4});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("beat2_valid", 64'(IN_VALID), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_in_valid", 64'(IN_VALID), 64'd0);
    check("rst_mid_bus", 64'({MODE, IN}), 64'd0);
    exp_in.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      OUT_VALID = 1'b1; OUT = 17'(i + 3);
      @(posedge clk); #1;
      OUT_VALID = 1'b0; OUT = '0;
      @(posedge clk); #1;
    end
    check("late_out_rsp", 64'(rsp_valid), 64'd0);
    check("late_out_ready", 64'(req_ready), 64'd1);
    send_req(2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    cnc_result(17'h00001, 17'h00002, 1);
    wait_rsp(50);

    // Back-to-back requests
    send_req(2'b11, 8'h55, 8'hAA, 8'h0F, 8'hF0, 1'b0);
    cnc_result(17'h12345, 17'h0FEDC, 0);
    wait_rsp(50);
    send_req(2'b10, 8'h80, 8'h7F, 8'hC0, 8'h3F, 1'b0);
    cnc_result(17'h1FFFF, 17'h00000, 0);
    wait_rsp(50);

    // Only one OUT beat returned
    send_req(2'b01, 8'h09, 8'h08, 8'h07, 8'h06, 1'b0);
    OUT_VALID = 1'b1; OUT = 17'h00005;
    @(posedge clk); #1;
    OUT_VALID = 1'b0; OUT = '0;
`ifdef CNC_FEEDER_TIMEOUT_EN
    exp_rsp.push_back('{data: {17'h00000, 17'h00005}, err: 1'b1});
    wait_rsp(100);
    check("err_cleared", 64'(rsp_err), 64'd0);
`else
    vcount = 0;
    repeat (100) begin
      if (rsp_valid) vcount++;
      @(posedge clk); #1;
    end
    check("no_timeout", 64'(vcount), 64'd0);
    OUT_VALID = 1'b1; OUT = 17'h00009;
    exp_rsp.push_back('{data: {17'h00009, 17'h00005}, err: 1'b0});
    @(posedge clk); #1;
    OUT_VALID = 1'b0; OUT = '0;
    wait_rsp(50);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("end_in_queue", 64'(exp_in.size()), 64'd0);
    check("end_rsp_queue", 64'(exp_rsp.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
